fp_issue_unit: RTL and testbench
================================

Name: fp_issue_unit

Overview:
- Upstream neighbour of the pipelined FPU. Holds the 32x32 FP register file and a one-entry issue register for decoded FP instructions.
- Selects operands with forwarding from the FPU E3 result (ed) and WB result (wd). Interlocks on RAW hazards against FPU stages E1/E2.
- Drives the FPU a/b/fc/wf/fd/ein inputs and commits FPU writebacks (ww/wn/wd) into the register file.

Parameters:
- CNT_W, 16, width of the wrapping test counters issued_cnt and stall_cnt.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  decoded FP instruction valid
- in_ready  out  1  issue register can accept this cycle
- in_fc  in  3  op code: 000 add, 001 sub, 01x mul, 10x div, 11x sqrt
- in_fs  in  5  source reg for operand a
- in_ft  in  5  source reg for operand b
- in_fd  in  5  destination reg
- in_wf  in  1  instruction writes the FP regfile
- e1w, e2w, e3w  in  1 each  FPU stage write flags
- e1n, e2n, e3n  in  5 each  FPU stage destination regs
- ed  in  32  FPU E3 result
- ww  in  1  FPU WB write enable
- wn  in  5  FPU WB destination
- wd  in  32  FPU WB data
- fpu_stall  in  1  FPU div/sqrt busy stall
- a, b  out  32 each  operands to FPU
- fc  out  3  op code to FPU
- wf  out  1  write flag to FPU
- fd  out  5  destination to FPU
- ein  out  1  issue enable to FPU
- raw_stall  out  1  RAW interlock active
- dbg_addr  in  5  debug read address
- dbg_data  out  32  debug read data, combinational
- issued_cnt  out  CNT_W  instructions issued
- stall_cnt  out  CNT_W  cycles with valid instruction not issued

Behaviour:
- State:
  - Issue register: vq, fcq, fsq, ftq, fdq, wfq.
  - regfile[0..31]. Register 0 is an ordinary register; no hardwiring.
  - issued_cnt, stall_cnt.
- Reset (async): vq=0; fcq/fsq/ftq/fdq=0; wfq=0; all regfile entries 0; both counters 0.
  - Consequences: ein=0, raw_stall=0, a=b=0, fc=0, fd=0, wf=0, in_ready=1.
  - Reset mid-operation discards any held instruction.
- Operand usage:
  - a uses fsq for every op.
  - b uses ftq for add/sub/mul/div.
  - sqrt (fcq[2:1]=11) ignores ftq for hazard purposes; b is still driven.
- Forwarding, per used source r, in priority order:
  1. e3w & e3n==r -> ed
  2. ww & wn==r -> wd
  3. regfile[r]
  - The same priority applies to dbg_data.
- RAW interlock: raw_stall = vq & (any used source r with (e1w & e1n==r) | (e2w & e2n==r)).
- Issue:
  - ein = vq & ~raw_stall.
  - issue = ein & ~fpu_stall. The FPU advances only when this holds.
- Handshake:
  - in_ready = ~vq | issue.
  - accept = in_valid & in_ready; on accept, the issue register loads in_*, vq=1.
  - issue without accept -> vq=0.
  - Simultaneous issue and accept -> new instruction loaded; back-to-back throughput is 1 per cycle.
- Regfile write: on each posedge with ww=1, regfile[wn] <= wd.
  - Repeated writes while the FPU holds WB during a stall are idempotent and allowed.
  - No read-during-write hazard: wd forwarding covers the same-cycle case.
- Counters (wrap at 2^CNT_W):
  - issued_cnt +1 per issue cycle.
  - stall_cnt +1 per cycle with vq & ~issue.
- Outputs a, b, fc, fd, wf are combinational from the issue register, forwarding and regfile. They are valid whenever vq=1 and are held stable while not issued.

Test Plan:
- Reset, then read dbg_addr 0..31 -> all 0; in_ready=1, ein=0, counters 0.
- Preload via ww=1, wn=3, wd=0x3F800000 and wn=4, wd=0x40000000. Issue add fs=3, ft=4, fd=5 with all stage w flags 0 -> same cycle ein=1, a=0x3F800000, b=0x40000000, fc=000; next cycle issued_cnt=1.
- Hold e1w=1, e1n=5; issue mul fs=5 -> raw_stall=1, ein=0, in_ready=0, stall_cnt increments each cycle. Move to e3w=1, e3n=5, ed=0x40400000 -> ein=1, a=0x40400000.
- Forward priority: e3w=1, e3n=7, ed=0x11111111 and simultaneously ww=1, wn=7, wd=0x22222222; issue with fs=7 -> a=0x11111111. Following cycle, regfile[7]=0x22222222 via dbg_data with no forwards active.
- sqrt fs=2, ft=9 with e1w=1, e1n=9 -> no raw_stall, ein=1. Same op as div fc=100 -> raw_stall=1.
- fpu_stall=1 for 10 cycles with a ready instruction -> ein=1, instruction held, in_ready=0, stall_cnt +10. Then fpu_stall=0 with in_valid=1 -> issue and accept in the same cycle; no bubble.

Source files
------------

// File: rtl/fp_issue_unit.sv
// FP issue stage: 32x32 register file, one-entry issue register, operand forwarding
// from FPU E3/WB, and RAW interlock against FPU stages E1/E2.
module fp_issue_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_fc,
  input  logic [4:0]       in_fs,
  input  logic [4:0]       in_ft,
  input  logic [4:0]       in_fd,
  input  logic             in_wf,
  input  logic             e1w,
  input  logic             e2w,
  input  logic             e3w,
  input  logic [4:0]       e1n,
  input  logic [4:0]       e2n,
  input  logic [4:0]       e3n,
  input  logic [31:0]      ed,
  input  logic             ww,
  input  logic [4:0]       wn,
  input  logic [31:0]      wd,
  input  logic             fpu_stall,
  output logic [31:0]      a,
  output logic [31:0]      b,
  output logic [2:0]       fc,
  output logic             wf,
  output logic [4:0]       fd,
  output logic             ein,
  output logic             raw_stall,
  input  logic [4:0]       dbg_addr,
  output logic [31:0]      dbg_data,
  output logic [CNT_W-1:0] issued_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  logic             r_vq;
  logic [2:0]       r_fc;
  logic [4:0]       r_fs;
  logic [4:0]       r_ft;
  logic [4:0]       r_fd;
  logic             r_wf;
  logic [31:0]      r_regfile [32];
  logic [CNT_W-1:0] r_issued_cnt;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_uses_b;
  logic w_haz_a;
  logic w_haz_b;
  logic w_issue;
  logic w_accept;

  // Forwarding priority: E3 result is younger than WB, WB is younger than the regfile.
  assign a = (e3w && e3n == r_fs) ? ed :
             (ww  && wn  == r_fs) ? wd : r_regfile[r_fs];
  assign b = (e3w && e3n == r_ft) ? ed :
             (ww  && wn  == r_ft) ? wd : r_regfile[r_ft];
  assign dbg_data = (e3w && e3n == dbg_addr) ? ed :
                    (ww  && wn  == dbg_addr) ? wd : r_regfile[dbg_addr];

  // sqrt takes a single operand, so ft never causes an interlock for it.
  assign w_uses_b  = (r_fc[2:1] != 2'b11);
  assign w_haz_a   = (e1w && e1n == r_fs) || (e2w && e2n == r_fs);
  assign w_haz_b   = (e1w && e1n == r_ft) || (e2w && e2n == r_ft);
  assign raw_stall = r_vq && (w_haz_a || (w_uses_b && w_haz_b));

  assign ein      = r_vq && !raw_stall;
  assign w_issue  = ein && !fpu_stall;
  assign in_ready = !r_vq || w_issue;
  assign w_accept = in_valid && in_ready;

  assign fc         = r_fc;
  assign fd         = r_fd;
  assign wf         = r_wf;
  assign issued_cnt = r_issued_cnt;
  assign stall_cnt  = r_stall_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vq <= 1'b0;
      r_fc <= '0;
      r_fs <= '0;
      r_ft <= '0;
      r_fd <= '0;
      r_wf <= 1'b0;
    end else if (w_accept) begin
      r_vq <= 1'b1;
      r_fc <= in_fc;
      r_fs <= in_fs;
      r_ft <= in_ft;
      r_fd <= in_fd;
      r_wf <= in_wf;
    end else if (w_issue) begin
      r_vq <= 1'b0;
    end
  end

  // NOTE: the regfile is built from flops and must read as zero after reset, so every entry is reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) r_regfile[i] <= '0;
    end else if (ww) begin
      r_regfile[wn] <= wd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_issued_cnt <= '0;
      r_stall_cnt  <= '0;
    end else begin
      if (w_issue)         r_issued_cnt <= r_issued_cnt + CNT_W'(1);
      if (r_vq && !w_issue) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fp_issue_unit.sv
// Bench for fp_issue_unit: directed instructions, expected issues queued at accept,
// popped and compared by a negedge monitor whenever the unit issues.
module tb_fp_issue_unit;

  localparam int CNT_W = 16;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  fc;
    logic [4:0]  fd;
    logic        wf;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_fc;
  logic [4:0]       in_fs, in_ft, in_fd;
  logic             in_wf;
  logic             e1w, e2w, e3w;
  logic [4:0]       e1n, e2n, e3n;
  logic [31:0]      ed;
  logic             ww;
  logic [4:0]       wn;
  logic [31:0]      wd;
  logic             fpu_stall;
  logic [31:0]      a, b;
  logic [2:0]       fc;
  logic             wf;
  logic [4:0]       fd;
  logic             ein, raw_stall;
  logic [4:0]       dbg_addr;
  logic [31:0]      dbg_data;
  logic [CNT_W-1:0] issued_cnt, stall_cnt;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  fp_issue_unit #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fc(in_fc), .in_fs(in_fs), .in_ft(in_ft), .in_fd(in_fd), .in_wf(in_wf),
    .e1w(e1w), .e2w(e2w), .e3w(e3w), .e1n(e1n), .e2n(e2n), .e3n(e3n),
    .ed(ed), .ww(ww), .wn(wn), .wd(wd), .fpu_stall(fpu_stall),
    .a(a), .b(b), .fc(fc), .wf(wf), .fd(fd), .ein(ein), .raw_stall(raw_stall),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .issued_cnt(issued_cnt), .stall_cnt(stall_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] f, input logic [4:0] s, input logic [4:0] t,
                      input logic [4:0] d, input exp_t e);
    in_valid = 1'b1;
    in_fc = f; in_fs = s; in_ft = t; in_fd = d; in_wf = 1'b1;
    exp_q.push_back(e);
  endtask

  // Monitor: every issue cycle must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && ein === 1'b1 && fpu_stall === 1'b0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_issue", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("issue_a",  a,  e.a);
        check("issue_b",  b,  e.b);
        check("issue_fc", {29'd0, fc}, {29'd0, e.fc});
        check("issue_fd", {27'd0, fd}, {27'd0, e.fd});
        check("issue_wf", {31'd0, wf}, {31'd0, e.wf});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_fc = '0; in_fs = '0; in_ft = '0; in_fd = '0; in_wf = 1'b0;
    e1w = 1'b0; e2w = 1'b0; e3w = 1'b0; e1n = '0; e2n = '0; e3n = '0; ed = '0;
    ww = 1'b0; wn = '0; wd = '0; fpu_stall = 1'b0; dbg_addr = '0;

    // Reset state
    #2;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_ein", {31'd0, ein}, 32'd0);
    check("rst_raw", {31'd0, raw_stall}, 32'd0);
    check("rst_a", a, 32'd0);
    check("rst_b", b, 32'd0);
    check("rst_fc_fd_wf", {23'd0, fc, fd, wf}, 32'd0);
    check("rst_issued", {16'd0, issued_cnt}, 32'd0);
    check("rst_stall", {16'd0, stall_cnt}, 32'd0);
    step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1;
      check("rst_regfile", dbg_data, 32'd0);
    end
    step();

    // Preload r3 = 1.0, r4 = 2.0
    ww = 1'b1; wn = 5'd3; wd = 32'h3F800000;
    step();
    wn = 5'd4; wd = 32'h40000000;
    step();
    ww = 1'b0;

    // add r5 = r3 + r4, no hazards
    send(3'b000, 5'd3, 5'd4, 5'd5, '{32'h3F800000, 32'h40000000, 3'b000, 5'd5, 1'b1});
    step();
    in_valid = 1'b0;
    check("add_ein", {31'd0, ein}, 32'd1);
    step();
    check("add_issued_cnt", {16'd0, issued_cnt}, 32'd1);
    check("add_stall_cnt", {16'd0, stall_cnt}, 32'd0);

    // mul on r5 while E1 writes r5 -> interlock, then forward from E3
    e1w = 1'b1; e1n = 5'd5;
    send(3'b010, 5'd5, 5'd4, 5'd6, '{32'h40400000, 32'h40000000, 3'b010, 5'd6, 1'b1});
    step();
    in_valid = 1'b0;
    check("raw_stall", {31'd0, raw_stall}, 32'd1);
    check("raw_ein", {31'd0, ein}, 32'd0);
    check("raw_in_ready", {31'd0, in_ready}, 32'd0);
    check("raw_stall_cnt0", {16'd0, stall_cnt}, 32'd0);
    step();
    check("raw_stall_cnt1", {16'd0, stall_cnt}, 32'd1);
    step();
    check("raw_stall_cnt2", {16'd0, stall_cnt}, 32'd2);
    e1w = 1'b0; e3w = 1'b1; e3n = 5'd5; ed = 32'h40400000;
    #1;
    check("e3_clear_raw", {31'd0, raw_stall}, 32'd0);
    check("e3_ein", {31'd0, ein}, 32'd1);
    step();
    e3w = 1'b0;
    check("mul_issued_cnt", {16'd0, issued_cnt}, 32'd2);
    check("mul_stall_cnt", {16'd0, stall_cnt}, 32'd2);

    // Forward priority: E3 beats WB for the same register
    e3w = 1'b1; e3n = 5'd7; ed = 32'h11111111;
    ww = 1'b1; wn = 5'd7; wd = 32'h22222222;
    send(3'b000, 5'd7, 5'd4, 5'd8, '{32'h11111111, 32'h40000000, 3'b000, 5'd8, 1'b1});
    step();
    in_valid = 1'b0;
    dbg_addr = 5'd7;
    #1;
    check("dbg_fwd_prio", dbg_data, 32'h11111111);
    step();
    e3w = 1'b0; ww = 1'b0;
    #1;
    check("dbg_r7_written", dbg_data, 32'h22222222);

    // sqrt ignores ft hazard; div with the same operands interlocks
    e1w = 1'b1; e1n = 5'd9;
    send(3'b110, 5'd2, 5'd9, 5'd10, '{32'd0, 32'd0, 3'b110, 5'd10, 1'b1});
    step();
    in_valid = 1'b0;
    check("sqrt_no_raw", {31'd0, raw_stall}, 32'd0);
    check("sqrt_ein", {31'd0, ein}, 32'd1);
    step();
    send(3'b100, 5'd2, 5'd9, 5'd10, '{32'd0, 32'd0, 3'b100, 5'd10, 1'b1});
    step();
    in_valid = 1'b0;
    check("div_raw", {31'd0, raw_stall}, 32'd1);
    check("div_ein", {31'd0, ein}, 32'd0);
    e1w = 1'b0;
    #1;
    check("div_ein_release", {31'd0, ein}, 32'd1);
    step();
    check("div_issued_cnt", {16'd0, issued_cnt}, 32'd5);

    // FPU stall: instruction held for 10 cycles, then issue and accept together
    fpu_stall = 1'b1;
    send(3'b001, 5'd3, 5'd4, 5'd11, '{32'h3F800000, 32'h40000000, 3'b001, 5'd11, 1'b1});
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("fstall_ein", {31'd0, ein}, 32'd1);
      check("fstall_in_ready", {31'd0, in_ready}, 32'd0);
      check("fstall_fd_held", {27'd0, fd}, 32'd11);
      step();
    end
    check("fstall_stall_cnt", {16'd0, stall_cnt}, 32'd12);
    fpu_stall = 1'b0;
    send(3'b011, 5'd4, 5'd3, 5'd12, '{32'h40000000, 32'h3F800000, 3'b011, 5'd12, 1'b1});
    #1;
    check("b2b_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    check("b2b_no_bubble", {31'd0, ein}, 32'd1);
    check("b2b_fd", {27'd0, fd}, 32'd12);
    step();
    check("final_issued_cnt", {16'd0, issued_cnt}, 32'd7);
    check("final_stall_cnt", {16'd0, stall_cnt}, 32'd12);
    check("queue_drained", exp_q.size(), 32'd0);

    // Reset mid-operation discards the held instruction and clears the regfile
    e1w = 1'b1; e1n = 5'd3;
    in_valid = 1'b1; in_fc = 3'b000; in_fs = 5'd3; in_ft = 5'd4; in_fd = 5'd13; in_wf = 1'b1;
    step();
    in_valid = 1'b0;
    check("pre_rst_raw", {31'd0, raw_stall}, 32'd1);
    rst_n = 1'b0;
    dbg_addr = 5'd3;
    #1;
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_raw", {31'd0, raw_stall}, 32'd0);
    check("mid_rst_regfile", dbg_data, 32'd0);
    check("mid_rst_counter", {16'd0, issued_cnt}, 32'd0);
    e1w = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
